// File: rtl/riscv_m_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: op codes, FSM states
// and a sign/magnitude helper used when operands are captured.
package riscv_m_pkg;

    localparam int M_XLEN = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } m_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        DONE = 2'b11
    } muldiv_state_e;

    typedef struct packed {
        logic              neg;
        logic [M_XLEN-1:0] mag;
    } signmag_t;

    // Splits a two's-complement value into sign and magnitude; unsigned
    // operands pass through untouched with a clear sign.
    function automatic signmag_t to_signmag(input logic [M_XLEN-1:0] v,
                                            input logic is_signed);
        signmag_t sm;
        sm.neg = is_signed & v[M_XLEN-1];
        sm.mag = sm.neg ? -v : v;
        return sm;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. Shift-add multiply and restoring
// divide share one double-width accumulator; one bit is processed per clock.
// Divide-by-zero and signed overflow bypass the iteration entirely.
module muldiv_unit
    import riscv_m_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [OPCODE_LENGTH-1:0] Funct3,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    input  logic                     flush,
    output logic                     busy,
    output logic                     done,
    output logic [DATA_WIDTH-1:0]    Result
);

    localparam int CW = $clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    muldiv_state_e state, state_next;

    logic [CW-1:0]           cnt;
    logic [2*DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0]   operand_b;
    m_op_e                   op;
    logic                    res_neg;
    logic                    rem_neg;
    logic [DATA_WIDTH-1:0]   result_q;

    m_op_e                   op_in;
    logic                    a_signed, b_signed;
    signmag_t                sm_a, sm_b;
    logic                    div_zero, div_ovf, fast;
    logic [DATA_WIDTH-1:0]   fast_result;

    logic [DATA_WIDTH:0]     mul_sum;
    logic [2*DATA_WIDTH-1:0] mul_next;
    logic                    div_ge;
    logic [DATA_WIDTH-1:0]   div_sub;
    logic [2*DATA_WIDTH-1:0] div_next;
    logic [2*DATA_WIDTH-1:0] step_next;
    logic [2*DATA_WIDTH-1:0] prod;
    logic [DATA_WIDTH-1:0]   quo, rem;
    logic [DATA_WIDTH-1:0]   final_result;

    logic                    iterating, launch, advance;

    assign iterating = (state == MUL) || (state == DIV);
    assign launch    = (state == IDLE) && start && !flush;
    assign advance   = iterating && !flush;

    assign busy   = iterating;
    assign done   = (state == DONE);
    assign Result = result_q;

    // Decode the incoming op: signedness of each operand and the special
    // divide cases that complete without iterating.
    always_comb begin
        op_in       = m_op_e'(Funct3);
        a_signed    = op_in inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
        b_signed    = op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
        sm_a        = to_signmag(SrcA, a_signed);
        sm_b        = to_signmag(SrcB, b_signed);
        div_zero    = Funct3[2] && (SrcB == '0);
        div_ovf     = (op_in inside {OP_DIV, OP_REM}) && (SrcA == MIN_NEG) && (SrcB == '1);
        fast        = div_zero || div_ovf;
        fast_result = '0;
        if (div_zero) begin
            fast_result = Funct3[1] ? SrcA : '1;
        end else if (div_ovf) begin
            fast_result = Funct3[1] ? '0 : MIN_NEG;
        end
    end

    // One iteration step of either datapath. The multiplier sits in the low
    // half and is shifted out as partial sums enter the high half; the divide
    // shifts the dividend into the remainder half and shifts quotient bits in.
    always_comb begin
        mul_sum   = {1'b0, acc[2*DATA_WIDTH-1:DATA_WIDTH]} + (acc[0] ? {1'b0, operand_b} : '0);
        mul_next  = {mul_sum, acc[DATA_WIDTH-1:1]};
        div_ge    = acc[2*DATA_WIDTH-1] || (acc[2*DATA_WIDTH-2:DATA_WIDTH-1] >= operand_b);
        div_sub   = acc[2*DATA_WIDTH-2:DATA_WIDTH-1] - operand_b;
        div_next  = div_ge ? {div_sub, acc[DATA_WIDTH-2:0], 1'b1}
                           : {acc[2*DATA_WIDTH-2:DATA_WIDTH-1], acc[DATA_WIDTH-2:0], 1'b0};
        step_next = (state == MUL) ? mul_next : div_next;
    end

    // Sign-correct the last step's output and pick the half the op returns.
    always_comb begin
        prod = res_neg ? -mul_next : mul_next;
        quo  = res_neg ? -div_next[DATA_WIDTH-1:0] : div_next[DATA_WIDTH-1:0];
        rem  = rem_neg ? -div_next[2*DATA_WIDTH-1:DATA_WIDTH] : div_next[2*DATA_WIDTH-1:DATA_WIDTH];
        case (op)
            OP_MUL:                       final_result = prod[DATA_WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_result = prod[2*DATA_WIDTH-1:DATA_WIDTH];
            OP_DIV, OP_DIVU:              final_result = quo;
            default:                      final_result = rem;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic; flush wins over both start and completion.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (launch) begin
                    if (fast)           state_next = DONE;
                    else if (Funct3[2]) state_next = DIV;
                    else                state_next = MUL;
                end
            end
            MUL, DIV: begin
                if (flush)                 state_next = IDLE;
                else if (cnt == CNT_LAST)  state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture on launch, iteration while running, result write on
    // the final step or immediately for the special divide cases.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            acc       <= '0;
            operand_b <= '0;
            op        <= OP_MUL;
            res_neg   <= 1'b0;
            rem_neg   <= 1'b0;
            result_q  <= '0;
        end else if (launch) begin
            cnt       <= '0;
            acc       <= {{DATA_WIDTH{1'b0}}, sm_a.mag};
            operand_b <= sm_b.mag;
            op        <= op_in;
            res_neg   <= sm_a.neg ^ sm_b.neg;
            rem_neg   <= sm_a.neg;
            if (fast) result_q <= fast_result;
        end else if (advance) begin
            acc <= step_next;
            cnt <= cnt + CNT_ONE;
            if (cnt == CNT_LAST) result_q <= final_result;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases, abort/reset paths and
// randomized ops compared against a plain-arithmetic reference model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  Funct3;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] Result;

    int compared   = 0;
    int mismatched = 0;

    muldiv_unit #(.DATA_WIDTH(32), .OPCODE_LENGTH(3)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .Funct3 (Funct3),
        .SrcA   (SrcA),
        .SrcB   (SrcB),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .Result (Result)
    );

    always #5 clk = ~clk;

    // Counts one comparison and reports it when observed differs from expected.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // RV32M semantics straight from the ISA definition using 64-bit math.
    function automatic logic [31:0] refModel(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
        logic signed [63:0] sa, sb, q, r;
        logic [63:0] ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                q = sa / sb;
                return q[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                r = sa % sb;
                return r[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int refLatency(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
        if (f3[2] && b == 0) return 0;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 0;
        return 32;
    endfunction

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Launches one op, optionally pokes start mid-flight, and checks latency,
    // result, busy during done and the single-cycle done pulse.
    task automatic applyStimulus(input string tag, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input bit poke);
        int edges = 0;
        int busyGaps = 0;
        int expLat = refLatency(f3, a, b);
        logic [31:0] expRes = refModel(f3, a, b);
        @(negedge clk);
        start = 1'b1; Funct3 = f3; SrcA = a; SrcB = b;
        @(posedge clk); #1;
        start = 1'b0;
        while (!done && edges < 40) begin
            if (!busy) busyGaps++;
            @(posedge clk); #1;
            edges++;
            if (poke && expLat != 0) begin
                if (edges == 4) begin
                    start = 1'b1; Funct3 = 3'($urandom); SrcA = $urandom; SrcB = $urandom;
                end else if (edges == 5) begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        checkOutput({tag, ".lat"}, 64'(edges), 64'(expLat));
        checkOutput({tag, ".res"}, {32'b0, Result}, {32'b0, expRes});
        checkOutput({tag, ".busyAtDone"}, {63'b0, busy}, 64'd0);
        checkOutput({tag, ".busyGaps"}, 64'(busyGaps), 64'd0);
        @(posedge clk); #1;
        checkOutput({tag, ".donePulse"}, {63'b0, done}, 64'd0);
    endtask

    initial begin
        int doneSeen;
        logic [31:0] held;
        reset = 1'b1; start = 1'b0; flush = 1'b0;
        Funct3 = 3'd0; SrcA = '0; SrcB = '0;
        #3;
        checkOutput("rst.busy", {63'b0, busy}, 64'd0);
        checkOutput("rst.done", {63'b0, done}, 64'd0);
        checkOutput("rst.result", {32'b0, Result}, 64'd0);
        @(negedge clk); reset = 1'b0;

        $display("[TB] directed ops");
        applyStimulus("mul7xm3",  3'd0, 32'd7,        32'hFFFFFFFD, 1'b0);
        checkOutput("mul7xm3.const", {32'b0, Result}, 64'hFFFFFFEB);
        applyStimulus("mulhu",    3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        checkOutput("mulhu.const", {32'b0, Result}, 64'hFFFFFFFE);
        applyStimulus("mulh",     3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        applyStimulus("mulhsu",   3'd2, 32'hFFFFFFFF, 32'd2,        1'b0);
        applyStimulus("div",      3'd4, 32'hFFFFFFF9, 32'd2,        1'b0);
        checkOutput("div.const", {32'b0, Result}, 64'hFFFFFFFD);
        applyStimulus("rem",      3'd6, 32'hFFFFFFF9, 32'd2,        1'b0);
        applyStimulus("divu",     3'd5, 32'd100,      32'd7,        1'b0);
        applyStimulus("remu",     3'd7, 32'd100,      32'd7,        1'b0);
        applyStimulus("divu0",    3'd5, 32'd5,        32'd0,        1'b0);
        applyStimulus("remu0",    3'd7, 32'd5,        32'd0,        1'b0);
        applyStimulus("remOvf",   3'd6, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        applyStimulus("divOvf",   3'd4, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        checkOutput("divOvf.const", {32'b0, Result}, 64'h80000000);

        $display("[TB] flush mid-multiply");
        held = Result;
        doneSeen = 0;
        @(negedge clk);
        start = 1'b1; Funct3 = 3'd0; SrcA = 32'd123; SrcB = 32'd456;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk); #1;
            if (done) doneSeen++;
        end
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        checkOutput("flush.busy", {63'b0, busy}, 64'd0);
        checkOutput("flush.doneSeen", 64'(doneSeen + int'(done)), 64'd0);
        checkOutput("flush.result", {32'b0, Result}, {32'b0, held});
        applyStimulus("afterFlush", 3'd1, 32'h12345678, 32'h9ABCDEF0, 1'b0);

        $display("[TB] start and flush together");
        held = Result;
        doneSeen = 0;
        @(negedge clk);
        start = 1'b1; flush = 1'b1; Funct3 = 3'd5; SrcA = 32'd9; SrcB = 32'd0;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        checkOutput("startFlush.busy", {63'b0, busy}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            if (done) doneSeen++;
            @(posedge clk); #1;
        end
        checkOutput("startFlush.doneSeen", 64'(doneSeen), 64'd0);
        checkOutput("startFlush.result", {32'b0, Result}, {32'b0, held});

        $display("[TB] async reset mid-divide");
        @(negedge clk);
        start = 1'b1; Funct3 = 3'd4; SrcA = 32'd1000; SrcB = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            @(posedge clk); #1;
        end
        #2 reset = 1'b1;
        #1;
        checkOutput("asyncRst.busy", {63'b0, busy}, 64'd0);
        checkOutput("asyncRst.done", {63'b0, done}, 64'd0);
        checkOutput("asyncRst.result", {32'b0, Result}, 64'd0);
        @(negedge clk); reset = 1'b0;
        applyStimulus("divu9by3", 3'd5, 32'd9, 32'd3, 1'b0);
        checkOutput("divu9by3.const", {32'b0, Result}, 64'd3);

        $display("[TB] randomized ops");
        for (int n = 0; n < 40; n++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            f3 = 3'($urandom);
            a  = pickOperand();
            b  = pickOperand();
            applyStimulus($sformatf("rnd%0d", n), f3, a, b, bit'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
